// File: rtl/adder_pipelined_pkg.sv
// Shared defaults and elaboration helpers for the pipelined add/subtract unit.
// Imported by the top so every instance derives its depth the same way.
package adder_pipelined_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int stage_count(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice: sum, carry out, and the carry into the
// slice MSB so the final slice can form the signed-overflow flag.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] full;

  assign full    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum     = full[CHUNK-1:0];
  assign cout    = full[CHUNK];
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
  assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/adder_pipelined.sv
// Pipelined add/subtract unit: a WIDTH-bit carry chain split into CHUNK-bit
// stages with a registered carry between stages and a valid/ready handshake.
module adder_pipelined
  import adder_pipelined_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);

  if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("adder_pipelined: WIDTH must be a positive multiple of CHUNK");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe moves as one (en); in_ready mirrors en combinationally,
  // so a stalled output drops in_ready in the same cycle.
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~in_b : in_b;
  assign c_eff    = carry_in ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_d, b_d, r_d;
    logic             c_d, v_d;
    logic [CHUNK-1:0] sum;
    logic             cout, msb_cin;
    logic             v_q, c_q;
    logic [WIDTH-1:0] a_q, b_q, r_q;

    if (k == 0) begin : g_src
      assign a_d = in_a;
      assign b_d = b_eff;
      assign r_d = '0;
      assign c_d = c_eff;
      assign v_d = in_valid;
    end else begin : g_src
      assign a_d = g_stage[k-1].a_q;
      assign b_d = g_stage[k-1].b_q;
      assign r_d = g_stage[k-1].r_q;
      assign c_d = g_stage[k-1].c_q;
      assign v_d = g_stage[k-1].v_q;
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (a_d[k*CHUNK +: CHUNK]),
      .b       (b_d[k*CHUNK +: CHUNK]),
      .cin     (c_d),
      .sum     (sum),
      .cout    (cout),
      .msb_cin (msb_cin)
    );

    // Lower result chunks ride along so every bit lands in the last stage together.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        r_q <= '0;
      end else if (en) begin
        v_q <= v_d;
        c_q <= cout;
        a_q <= a_d;
        b_q <= b_d;
        r_q <= r_d;
        r_q[k*CHUNK +: CHUNK] <= sum;
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= msb_cin ^ cout;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out       = g_stage[STAGES-1].r_q;
  assign carry_out = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_adder_pipelined.sv
// Self-checking bench for adder_pipelined (WIDTH=16, CHUNK=4): directed vector
// table, stall and reset sequences, and a random stream against a reference model.
module tb_adder_pipelined;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int W     = WIDTH + 2;  // {overflow, carry_out, out}

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             overflow;

  adder_pipelined #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         held_v = 1'b0;
  logic [W-1:0] held;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic logic [W-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sb);
    int ua, ub, sa, sbv, ci, full, sr;
    logic c, v;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    ci  = cin ? 1 : 0;
    if (!sb) begin
      full = ua + ub + ci;
      sr   = sa + sbv + ci;
      c    = (full > 65535);
    end else begin
      full = ua - ub - ci;
      sr   = sa - sbv - ci;
      c    = (full >= 0);
    end
    v = (sr > 32767) || (sr < -32768);
    return {v, c, full[15:0]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({overflow, carry_out, out}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h with empty expected queue", {overflow, carry_out, out});
        end else begin
          check("scoreboard", 32'({overflow, carry_out, out}), 32'(exp_q.pop_front()));
        end
      end
      held_v = out_valid && !out_ready;
      held   = {overflow, carry_out, out};
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, carry_in, sub));
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sb);
    logic acc;
    int   guard;
    in_a = a; in_b = b; carry_in = cin; sub = sb; in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    in_a = v.a; in_b = v.b; carry_in = v.cin; sub = v.sub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_out"}, 32'(out), 32'(v.res));
    check({tag, "_carry"}, 32'(carry_out), 32'(v.cout));
    check({tag, "_ovf"}, 32'(overflow), 32'(v.ovf));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; carry_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1;

    // Reset with toggling inputs.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_a = 16'($urandom); in_b = 16'($urandom);
      carry_in = 1'($urandom); sub = 1'($urandom);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    @(posedge clk);
    #1;
    wait_drain();

    // Back-to-back burst with a 3-cycle output stall mid-stream.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          check("stall_front", 32'({overflow, carry_out, out}), 32'(exp_q[0]));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with three operations in flight.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      send_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("midrst_no_emit", 32'(seen), 32'd0);
    end
    run_vec(vecs[2], "post_rst");
    @(posedge clk);
    #1;
    wait_drain();

    // Random stream with random backpressure.
    begin
      logic acc;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_a = 16'($urandom); in_b = 16'($urandom);
          carry_in = 1'($urandom); sub = 1'($urandom);
          if ($urandom_range(0, 7) == 0) in_b = in_a;
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    wait_drain();

    // Final report.
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
